// File: rtl/nand_serial_pkg.sv
// Shared types and defaults for the bit-serial NAND engine.
package nand_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/nand_gate.sv
// Single two-input NAND; the only datapath element of the serial engine.
module nand_gate (
  input  logic inA,
  input  logic inB,
  output logic outY
);

  assign outY = ~(inA & inB);

endmodule

// File: rtl/nand_serial_8bit.sv
// Bit-serial ~(A&B): operands stream LSB-first through one nand_gate,
// result reassembled in a shift register and published on completion.
module nand_serial_8bit
  import nand_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inStart,
  output logic             outBusy,
  output logic             outDone,
  output logic [WIDTH-1:0] outY
);

  // state | meaning
  // IDLE  | waiting for inStart; operands captured on the accepting edge
  // SHIFT | one result bit per edge, WIDTH edges total
  // DONE  | single-cycle completion pulse, then back to IDLE

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("nand_serial_8bit: WIDTH must be at least 2");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_out_y;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_bit;
  logic               w_last;
  logic               w_accept;

  nand_gate u_nand (
    .inA  (r_a[0]),
    .inB  (r_b[0]),
    .outY (w_bit)
  );

  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_accept = (r_state == IDLE) && inStart;

  // Busy/done are registered from the next state so the outputs are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
      r_done  <= (w_state_next == DONE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (inStart) w_state_next = SHIFT;
      SHIFT:   if (w_last)  w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    outBusy = r_busy;
    outDone = r_done;
    outY    = r_out_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_out_y <= '0;
    end else if (w_accept) begin
      r_a   <= inA;
      r_b   <= inB;
      r_y   <= '0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_y   <= {w_bit, r_y[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      // Publish the whole word at once so outY never shows a partial result.
      if (w_last) begin
        r_out_y <= {w_bit, r_y[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_nand_serial_8bit.sv
// Self-checking bench for nand_serial_8bit: vector table, hand sequences,
// random ops, with a scoreboard fed at accept and drained at done.
module tb_nand_serial_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inA = '0;
  logic [7:0] inB = '0;
  logic       inStart = 1'b0;
  logic       outBusy;
  logic       outDone;
  logic [7:0] outY;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  logic [7:0] last_y = 8'h00;
  logic [7:0] prev_y = 8'h00;
  logic       prev_done = 1'b0;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t vecs[7];

  nand_serial_8bit dut (
    .clk     (clk),
    .rst     (rst),
    .inA     (inA),
    .inB     (inB),
    .inStart (inStart),
    .outBusy (outBusy),
    .outDone (outDone),
    .outY    (outY)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: predict on accept, compare on done; also watches outY stability.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_done = 1'b0;
    end else begin
      if (inStart && !outBusy) sb_q.push_back(~(inA & inB));
      if (outDone) begin
        n_done++;
        check("done_not_back_to_back", {31'd0, prev_done}, 32'd0);
        if (sb_q.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          check("sb_result", {24'd0, outY}, {24'd0, sb_q.pop_front()});
        end
      end else if (outY !== prev_y) begin
        check("outY_changed_without_done", {24'd0, outY}, {24'd0, prev_y});
      end
      prev_done = outDone;
    end
    prev_y = outY;
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 30 && outBusy; k++) begin
      @(posedge clk); #1;
    end
    if (outBusy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                       input string nm, input bit scramble);
    int busy;
    int lat;
    bit seen;
    wait_idle();
    inA = a; inB = b; inStart = 1'b1;
    @(posedge clk); #1;
    inStart = 1'b0;
    if (scramble) begin
      inA = 8'($urandom); inB = 8'($urandom);
    end
    busy = outBusy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (k == 4) check({nm, "_hold_prev"}, {24'd0, outY}, {24'd0, last_y});
      if (outBusy) busy++;
      if (outDone) begin
        seen = 1'b1;
        lat = k;
      end
    end
    if (!seen) begin
      check({nm, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      check({nm, "_latency"}, lat, 8);
      check({nm, "_result"}, {24'd0, outY}, {24'd0, exp});
      last_y = exp;
      @(posedge clk); #1;
      check({nm, "_busy_cycles"}, busy, 9);
      check({nm, "_idle_after"}, {30'd0, outBusy, outDone}, 32'd0);
    end
  endtask

  initial begin
    int d0;
    int cyc;
    int last_cyc;
    int n_pulses;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{8'hF0, 8'h3C, 8'hCF};
    vecs[1] = '{8'h00, 8'h00, 8'hFF};
    vecs[2] = '{8'h0F, 8'hFF, 8'hF0};
    vecs[3] = '{8'h33, 8'h33, 8'hCC};
    vecs[4] = '{8'hA5, 8'h5A, 8'hFF};
    vecs[5] = '{8'hAA, 8'hAA, 8'h55};
    vecs[6] = '{8'h81, 8'hFF, 8'h7E};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, outBusy}, 32'd0);
    check("reset_done", {31'd0, outDone}, 32'd0);
    check("reset_y", {24'd0, outY}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'hFF, 8'hFF, 8'h00, "ff_ff", 1'b0);

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].y, $sformatf("vec%0d", i), 1'b0);
    end

    // Operand change plus extra start mid-flight must be ignored.
    wait_idle();
    inA = 8'hA5; inB = 8'h5A; inStart = 1'b1;
    @(posedge clk); #1;
    inStart = 1'b0;
    d0 = n_done;
    repeat (3) @(posedge clk);
    #1;
    inA = 8'hFF; inB = 8'hFF; inStart = 1'b1;
    @(posedge clk); #1;
    inStart = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midflight_done_count", n_done - d0, 1);
    check("midflight_result", {24'd0, outY}, 32'hFF);
    check("midflight_idle", {31'd0, outBusy}, 32'd0);
    last_y = 8'hFF;

    // Level-held start: one op every WIDTH+2 cycles.
    wait_idle();
    inA = 8'h0F; inB = 8'hFF; inStart = 1'b1;
    cyc = 0; last_cyc = -1; n_pulses = 0;
    for (int k = 0; k < 35; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (outDone) begin
        n_pulses++;
        check("held_result", {24'd0, outY}, 32'hF0);
        if (last_cyc >= 0) check("held_period", cyc - last_cyc, 10);
        last_cyc = cyc;
      end
    end
    check("held_pulse_count", n_pulses, 3);
    inStart = 1'b0;
    wait_idle();
    last_y = 8'hF0;

    // Reset at edge 4 of an op aborts with no done pulse.
    inA = 8'h33; inB = 8'h33; inStart = 1'b1;
    @(posedge clk); #1;
    inStart = 1'b0;
    d0 = n_done;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, outBusy}, 32'd0);
    check("abort_done", {31'd0, outDone}, 32'd0);
    check("abort_y", {24'd0, outY}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    last_y = 8'h00;
    do_op(8'h33, 8'h33, 8'hCC, "after_abort", 1'b0);

    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, ~(ra & rb), "rand", 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nand_serial_8bit.md
Name: nand_serial_8bit

Overview:
- Bit-serial, sequential counterpart to the parallel 8-bit NAND bank.
- Captures two 8-bit operands on a start pulse and streams them LSB-first through one shared nand_gate instance, one bit per clock.
- Reassembles the 8-bit result and flags completion with a one-cycle done pulse.
- Used where area matters more than latency, and as a sequential test target for the simulator.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2.
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- inA  input  WIDTH  operand A; sampled only on the accepting edge.
- inB  input  WIDTH  operand B; sampled only on the accepting edge.
- inStart  input  1  request. Accepted only when outBusy=0.
- outBusy  output  1  high while state ≠ IDLE.
- outDone  output  1  one-cycle completion pulse.
- outY  output  WIDTH  result ~(A&B). Holds the last completed value.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, outBusy=0, outDone=0, outY=0, shift registers=0, counter=0. Reset asserted mid-operation aborts immediately; no done pulse is produced for the aborted op.
- States: IDLE, SHIFT, DONE.
  - IDLE: on an edge with inStart=1, load regA←inA, regB←inB, regY←0, cnt←0, and go to SHIFT. With inStart=0, stay in IDLE.
  - SHIFT: every edge:
    - bit = nand_gate(regA[0], regB[0]);
    - regY←{bit, regY[WIDTH-1:1]};
    - regA, regB shift right with 0 fill;
    - cnt++.
    - On the edge where cnt==WIDTH-1, also load outY←{bit, regY[WIDTH-1:1]} and go to DONE.
  - DONE: outDone=1 for exactly this one cycle. Next edge unconditionally returns to IDLE.
- Latency: if the accepting edge is E0, the WIDTH shift edges are E1..E_WIDTH. outY updates at E_WIDTH. outDone is high from E_WIDTH to E_WIDTH+1. For WIDTH=8, outY is valid 8 edges after accept.
- Throughput: one op per WIDTH+2 cycles minimum (accept → next accept).
- outDone is registered (state==DONE), so it is glitch-free.
- inStart while outBusy=1 (SHIFT or DONE) is ignored, not queued. A level-held inStart re-triggers in IDLE on the edge after DONE.
- Changes on inA/inB after accept have no effect on the in-flight result.
- outY changes only at the completion edge or on reset. It is never partially updated while SHIFT is active.

Decomposition:
- Package nand_serial_pkg:
  - state_t enum {IDLE, SHIFT, DONE};
  - localparam default WIDTH=8.
- Sub-module: reuse the existing nand_gate (inA, inB, outY) as the single datapath instance. Counter, shifters and FSM stay inline.

Test Plan:
- Reset, then inStart with A=0xFF, B=0xFF → outDone pulses 8 edges after accept; outY=0x00; outBusy high for 9 cycles.
- A=0xF0, B=0x3C → outY=0xCF. Then A=0x00, B=0x00 → outY=0xFF, with outY holding 0xCF until the second completion edge.
- Start A=0xA5, B=0x5A; change inA/inB to 0xFF/0xFF and pulse inStart at edge 3 → outY=0xFF (original operands), the extra start is ignored, and exactly one done pulse occurs.
- Hold inStart=1 continuously with A=0x0F, B=0xFF → a done pulse every 10 cycles; outY=0xF0 each time.
- Assert rst at edge 4 of an op with A=0x33, B=0x33 → immediately outBusy=0, outDone=0, outY=0x00. A new start with A=0x33, B=0x33 then completes with outY=0xCC.
- Randomised 500 ops comparing against the ~(A&B) model, with checks that outDone is never asserted twice consecutively.
